regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-port controller for the 32x64 register file (`registerFile`).
- Shares the register file's single write port between two write-back requesters (req0 = ALU result, req1 = load data) using a valid/ready handshake and round-robin arbitration.
- After reset, runs an init sweep that writes INIT_VAL into every register before normal traffic is allowed.
- Drives the register file's RD, WriteData and RegWrite inputs from registered outputs.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of registers swept at init
- INIT_VAL, 0, value written to every register during init

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req0_valid  in  1  ALU write-back request
- req0_rd  in  ADDR_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid  in  1  load write-back request
- req1_rd  in  ADDR_W  load destination register
- req1_data  in  DATA_W  load data
- req1_ready  out  1  load request accepted this cycle
- rf_rd  out  ADDR_W  to register file RD
- rf_wdata  out  DATA_W  to register file WriteData
- rf_regwrite  out  1  to register file RegWrite
- init_done  out  1  high once the init sweep has completed
- rs1, rs2  in  ADDR_W  read indices (same values the register file sees)
- rf_rdata1, rf_rdata2  in  DATA_W  register file ReadData1/ReadData2
- rdata1, rdata2  out  DATA_W  read data delivered to the datapath

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=INIT, init counter=0, rr pointer=0 (next tie goes to req0).
  - rf_regwrite=0, rf_rd=0, rf_wdata=0, init_done=0.
  - Both readys are 0 during reset.
  - Reset asserted mid-operation or mid-init: in-flight write is dropped (not issued next cycle); sweep restarts from register 0.
- State INIT (one register per cycle):
  - Registered outputs: rf_regwrite=1, rf_rd=counter, rf_wdata=INIT_VAL; counter then increments.
  - After the write for NUM_REGS-1 is issued, next state=RUN.
  - Init writes occupy NUM_REGS consecutive cycles.
  - req0_ready=req1_ready=0 throughout INIT, whatever the valids.
- State RUN:
  - init_done=1.
  - Arbitration is combinational; readys depend on the valids and the rr pointer only, never on ready.
  - Only reqN valid: that requester is granted, so readyN=1.
  - Both valid: grant the requester indicated by the rr pointer.
  - Neither valid: both readys 0.
  - A transfer is accepted when valid&&ready. At most one transfer per cycle.
  - On acceptance, the rr pointer moves to the other requester. The pointer is unchanged when no transfer occurs.
  - Accepted transfer with rd!=0: next cycle rf_regwrite=1 with rf_rd/rf_wdata = accepted rd/data.
  - Accepted transfer with rd==0: accepted and consumed, but rf_regwrite=0 next cycle, so x0 is never written.
  - No transfer: rf_regwrite=0 next cycle; rf_rd/rf_wdata hold their last values.
  - Latency from acceptance to register contents: rf_* are valid in cycle N+1, and the register file captures at the end of cycle N+1.
  - Same rd on back-to-back transfers: writes land in acceptance order, last one wins.
- Requester contract: rd/data held stable while valid && !ready. The controller does not check this.
- Reads (rdata1/rdata2) in the base build: rdata1=rf_rdata1 and rdata2=rf_rdata2, combinational passthrough.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - rdata1 = rf_wdata when rf_regwrite && rf_rd==rs1 && rs1!=0; otherwise rdata1 = rf_rdata1. rdata2 uses the same rule with rs2.
  - This hides the one-cycle write latency from a same-cycle reader.
  - Bypass is active during INIT as well (except for index 0).
- Not defined: pure passthrough. Ports are identical in both builds.

Decomposition:
- Package regfile_ctrl_pkg:
  - state typedef {INIT, RUN}.
  - Default localparams for DATA_W, ADDR_W, NUM_REGS.
  - Requester-index constants REQ_ALU=0, REQ_LOAD=1.
- Sub-module rr_arb2:
  - Two-input round-robin arbiter.
  - Inputs: valid[1:0], accept, enable; output: one-hot grant[1:0].
  - Holds the rr pointer internally; reset is synchronous active-low.

Test Plan:
- Reset low 3 cycles, then high:
  - rf_regwrite=1 for exactly 32 cycles with rf_rd 0..31 and rf_wdata=0.
  - init_done rises on cycle 33.
  - req0_valid=1 throughout gives req0_ready=0 until init_done.
- RUN, req0 only (rd=5, data=0xAA):
  - req0_ready=1 the same cycle.
  - Next cycle rf_regwrite=1, rf_rd=5, rf_wdata=0xAA.
  - Register 5 reads 0xAA afterwards.
- Both valid continuously (req0 rd=1..4, req1 rd=10..13):
  - Grants alternate 0,1,0,1, starting with req0 after reset.
  - rf_rd sequence 1,10,2,11,3,12,4,13; one write per cycle, no gaps.
- req1 rd=0, data=0xFF:
  - req1_ready=1 and the transfer is consumed.
  - rf_regwrite stays 0; register 0 reads 0.
- Reset low during RUN while req0 is accepted the same cycle:
  - No write issued next cycle; sweep restarts at rf_rd=0.
  - All registers read INIT_VAL after the sweep.
- REGFILE_WB_BYPASS_EN build, write rd=7, data=0x1234 issued while rs1=7:
  - rdata1=0x1234 during the rf_regwrite cycle, while rf_rdata1 still shows the old value.
  - Same test with rs1=0 gives rdata1=rf_rdata1.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the register-file write-back controller.
// Optional read bypass in the top is enabled by defining REGFILE_WB_BYPASS_EN.
package regfile_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF   = 64;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;

    // Bit positions of each requester in the valid/grant vectors.
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer advances
// past the granted requester whenever a transfer is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    input  logic       enable,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After serving requester 0 the next tie goes to requester 1, and vice versa.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (accept && enable) begin
            r_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the register file: init sweep, then round-robin
// write-back of ALU/load results. Define REGFILE_WB_BYPASS_EN for read bypass.
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                NUM_REGS = NUM_REGS_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_regwrite,
    output logic              init_done,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    // One extra bit so the counter can reach NUM_REGS and mark the sweep finished.
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_wdata;
    logic              r_init_done;

    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic              w_enable;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;

    assign w_valid    = {req1_valid, req0_valid};
    assign w_enable   = (r_state == RUN) && reset;
    assign w_accept   = |(w_grant & w_valid);
    assign w_sel_rd   = w_grant[REQ_LOAD] ? req1_rd   : req0_rd;
    assign w_sel_data = w_grant[REQ_LOAD] ? req1_data : req0_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  (w_valid),
        .accept (w_accept),
        .enable (w_enable),
        .grant  (w_grant)
    );

    assign req0_ready = w_grant[REQ_ALU];
    assign req1_ready = w_grant[REQ_LOAD];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_regwrite  <= 1'b0;
            r_rd        <= '0;
            r_wdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_cnt < CNT_W'(NUM_REGS)) begin
                        r_regwrite <= 1'b1;
                        r_rd       <= ADDR_W'(r_cnt);
                        r_wdata    <= INIT_VAL;
                        r_cnt      <= r_cnt + 1'b1;
                    end else begin
                        r_regwrite  <= 1'b0;
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_init_done <= 1'b1;
                    r_regwrite  <= 1'b0;
                    // Writes to x0 are consumed but never reach the register file.
                    if (w_accept && (w_sel_rd != '0)) begin
                        r_regwrite <= 1'b1;
                        r_rd       <= w_sel_rd;
                        r_wdata    <= w_sel_data;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign rf_regwrite = r_regwrite;
    assign rf_rd       = r_rd;
    assign rf_wdata    = r_wdata;
    assign init_done   = r_init_done;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the write in flight so a same-cycle reader sees the new value.
    assign rdata1 = (r_regwrite && (r_rd == rs1) && (rs1 != '0)) ? r_wdata : rf_rdata1;
    assign rdata2 = (r_regwrite && (r_rd == rs2) && (rs2 != '0)) ? r_wdata : rf_rdata2;
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{rs1, rs2};
    assign rdata1      = rf_rdata1;
    assign rdata2      = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural 32x64 register file.
// Build with REGFILE_WB_BYPASS_EN defined to exercise the read bypass.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic        rf_regwrite;
    logic        init_done;
    logic [4:0]  rs1, rs2;
    logic [63:0] rf_rdata1, rf_rdata2;
    logic [63:0] rdata1, rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .rf_regwrite (rf_regwrite),
        .init_done   (init_done),
        .rs1         (rs1),
        .rs2         (rs2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rdata1      (rdata1),
        .rdata2      (rdata2)
    );

    // Register file model: write at end of the rf_regwrite cycle, async read.
    logic [63:0] regs [32];
    initial for (int i = 0; i < 32; i++) regs[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    always @(posedge clk) if (rf_regwrite) regs[rf_rd] <= rf_wdata;
    assign rf_rdata1 = regs[rs1];
    assign rf_rdata2 = regs[rs2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rd_seq [8];
    logic [63:0] exp_data;
    int i0, i1, g;

    initial begin
        rd_seq = '{1, 10, 2, 11, 3, 12, 4, 13};
        reset = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 64'h0;
        req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 64'h0;
        rs1 = 5'd0; rs2 = 5'd0;

        // Reset for 3 cycles
        repeat (3) tick();
        check_eq("rst_regwrite", 64'(rf_regwrite), 64'd0);
        check_eq("rst_rd", 64'(rf_rd), 64'd0);
        check_eq("rst_wdata", rf_wdata, 64'd0);
        check_eq("rst_init_done", 64'(init_done), 64'd0);
        check_eq("rst_ready0", 64'(req0_ready), 64'd0);

        // Init sweep: cycles 1..32 write registers 0..31 with INIT_VAL
        reset = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tick();
            check_eq("init_regwrite", 64'(rf_regwrite), 64'd1);
            check_eq("init_rd", 64'(rf_rd), 64'(c));
            check_eq("init_wdata", rf_wdata, 64'd0);
            check_eq("init_done_low", 64'(init_done), 64'd0);
            check_eq("init_ready0", 64'(req0_ready), 64'd0);
        end
        tick();
        check_eq("init_done_c33", 64'(init_done), 64'd1);
        check_eq("init_end_regwrite", 64'(rf_regwrite), 64'd0);
        check_eq("run_ready0", 64'(req0_ready), 64'd1);
        req0_valid = 1'b0;

        // Both requesters valid: grants alternate starting with req0
        i0 = 0; i1 = 0;
        for (int t = 0; t <= 8; t++) begin
            if (t > 0) begin
                exp_data = ((t - 1) % 2 == 0) ? 64'h100 + 64'(rd_seq[t-1]) : 64'h200 + 64'(rd_seq[t-1]);
                check_eq("rr_regwrite", 64'(rf_regwrite), 64'd1);
                check_eq("rr_rd", 64'(rf_rd), 64'(rd_seq[t-1]));
                check_eq("rr_wdata", rf_wdata, exp_data);
                $display("wb t=%0d rd=%0d data=%h", t - 1, rf_rd, rf_wdata);
            end
            if (t < 8) begin
                req0_valid = (i0 < 4);
                req0_rd    = 5'(1 + i0);
                req0_data  = 64'h100 + 64'(1 + i0);
                req1_valid = (i1 < 4);
                req1_rd    = 5'(10 + i1);
                req1_data  = 64'h200 + 64'(10 + i1);
                #1;
                g = t % 2;
                check_eq("rr_ready0", 64'(req0_ready), 64'(g == 0));
                check_eq("rr_ready1", 64'(req1_ready), 64'(g == 1));
                if (g == 0) i0++; else i1++;
                tick();
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        tick();
        check_eq("idle_regwrite", 64'(rf_regwrite), 64'd0);
        check_eq("idle_rd_hold", 64'(rf_rd), 64'd13);
        rs1 = 5'd1; rs2 = 5'd13; #1;
        check_eq("rd_reg1", rdata1, 64'h101);
        check_eq("rd_reg13", rdata2, 64'h20D);

        // req0 alone, rd=5
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 64'hAA; #1;
        check_eq("solo_ready0", 64'(req0_ready), 64'd1);
        check_eq("solo_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        check_eq("solo_regwrite", 64'(rf_regwrite), 64'd1);
        check_eq("solo_rd", 64'(rf_rd), 64'd5);
        check_eq("solo_wdata", rf_wdata, 64'hAA);
        $display("wb rd=%0d data=%h", rf_rd, rf_wdata);
        tick();
        rs1 = 5'd5; #1;
        check_eq("solo_reg5", rdata1, 64'hAA);

        // req1 writes x0: consumed, never written
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 64'hFF; #1;
        check_eq("x0_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check_eq("x0_regwrite", 64'(rf_regwrite), 64'd0);
        tick();
        rs1 = 5'd0; #1;
        check_eq("x0_reg0", rdata1, 64'd0);
        check_eq("x0_ready1_after", 64'(req1_ready), 64'd0);

        // Same-cycle read of a register being written
        rs1 = 5'd7; rs2 = 5'd0;
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 64'h1234; #1;
        check_eq("byp_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        check_eq("byp_regwrite", 64'(rf_regwrite), 64'd1);
`ifdef REGFILE_WB_BYPASS_EN
        check_eq("byp_rdata1", rdata1, 64'h1234);
`else
        check_eq("byp_rdata1", rdata1, 64'd0);
`endif
        check_eq("byp_rdata2_x0", rdata2, 64'd0);
        tick();
        check_eq("byp_after_write", rdata1, 64'h1234);

        // Reset while req0 is presenting a write: dropped, sweep restarts at 0
        reset = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 64'h99; #1;
        check_eq("rst2_ready0", 64'(req0_ready), 64'd0);
        tick();
        reset = 1'b1;
        req0_valid = 1'b0;
        check_eq("rst2_regwrite", 64'(rf_regwrite), 64'd0);
        check_eq("rst2_rd", 64'(rf_rd), 64'd0);
        check_eq("rst2_init_done", 64'(init_done), 64'd0);
        for (int c = 0; c < 32; c++) begin
            tick();
            check_eq("rst2_sweep_we", 64'(rf_regwrite), 64'd1);
            check_eq("rst2_sweep_rd", 64'(rf_rd), 64'(c));
        end
        tick();
        check_eq("rst2_init_done_hi", 64'(init_done), 64'd1);
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); #1;
            check_eq("rst2_reg_init", rdata1, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
